// File: rtl/pacman_vga_timing_pkg.sv
// pacman_vga_timing_pkg
//   Shared constants for the Pacman display timing block.
//   - 800x600@60 raster constants (40 MHz pixel clock): active area,
//     porches, sync widths, totals and sync polarity.
//   - Pacman game field dimensions (224x288 game pixels).
//   - Helper that computes the centring offset of a scaled window.
package pacman_vga_timing_pkg;

  // 800x600@60 raster
  localparam int VGA_H_ACTIVE = 800;
  localparam int VGA_H_FP     = 40;
  localparam int VGA_H_SYNC   = 128;
  localparam int VGA_H_BP     = 88;
  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int VGA_V_ACTIVE = 600;
  localparam int VGA_V_FP     = 1;
  localparam int VGA_V_SYNC   = 4;
  localparam int VGA_V_BP     = 23;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam bit VGA_SYNC_POL = 1'b1;

  // Pacman game field
  localparam int PACMAN_H_VISIBLE_AREA = 224;
  localparam int PACMAN_V_VISIBLE_AREA = 288;
  localparam int PACMAN_SCALE          = 2;

  // Spare room around a scaled window; negative means it does not fit.
  function automatic int win_slack(input int active, input int game, input int scale);
    return active - game * scale;
  endfunction

endpackage

// File: rtl/pacman_sync_delay.sv
// pacman_sync_delay
//   Fixed-depth shift register used to line up the sync/enable outputs
//   with downstream registered pipeline stages.
//   Parameters: DEPTH (stages, >= 1), WIDTH (bits), RST_VAL (value loaded
//   into every stage while reset is asserted).
//   Ports:
//     clk   in          clock
//     rst_n in          asynchronous active-low reset
//     din   in  [WIDTH] data entering the first stage
//     dout  out [WIDTH] data leaving the last stage (DEPTH cycles later)
module pacman_sync_delay
  import pacman_vga_timing_pkg::*;
#(
  parameter int               DEPTH   = 2,
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  always_comb begin
    stage_d[0] = din;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= RST_VAL;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/pacman_vga_timing.sv
// pacman_vga_timing
//   Raster timing generator for the Pacman renderer. Produces 800x600@60
//   VGA timing from a single 40 MHz pixel clock and centres the game field
//   (GAME_W x GAME_H, scaled by SCALE in both axes) inside the visible area.
//   Every output is registered; the outputs after clock edge n describe
//   raster position n, with the first edge after reset describing (0,0).
//
//   Ports:
//     clk             in   pixel clock
//     rst_n           in   asynchronous active-low reset
//     hsync           out  horizontal sync, SYNC_POL when active
//     vsync           out  vertical sync, SYNC_POL when active
//     display_enabled out  position inside the visible area
//     game_pix_stb    out  position inside the scaled game window
//     frame_stb       out  one-cycle pulse at position (0,0)
//     sx              out  game column, 0 outside the game window
//     sy              out  game row, 0 outside the game window
//
//   Build option: PACMAN_TIMING_PIPE_EN
//     When defined, hsync, vsync and display_enabled are delayed by two
//     extra cycles to match the renderer's sprite-hit and RGB registers.
//     sx, sy, game_pix_stb and frame_stb keep their single-register timing.
module pacman_vga_timing
  import pacman_vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter bit SYNC_POL = VGA_SYNC_POL,
  parameter int SCALE    = PACMAN_SCALE,
  parameter int GAME_W   = PACMAN_H_VISIBLE_AREA,
  parameter int GAME_H   = PACMAN_V_VISIBLE_AREA
) (
  input  logic                      clk,
  input  logic                      rst_n,
  output logic                      hsync,
  output logic                      vsync,
  output logic                      display_enabled,
  output logic                      game_pix_stb,
  output logic                      frame_stb,
  output logic [$clog2(GAME_W)-1:0] sx,
  output logic [$clog2(GAME_H)-1:0] sy
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_SLACK = win_slack(H_ACTIVE, GAME_W, SCALE);
  localparam int V_SLACK = win_slack(V_ACTIVE, GAME_H, SCALE);
  localparam int H_OFF   = H_SLACK / 2;
  localparam int V_OFF   = V_SLACK / 2;

  localparam int HW   = $clog2(H_TOTAL);
  localparam int VW   = $clog2(V_TOTAL);
  localparam int SXW  = $clog2(GAME_W);
  localparam int SYW  = $clog2(GAME_H);
  localparam int SUBW = (SCALE > 1) ? $clog2(SCALE) : 1;

  // Sized compare points so every comparison is width-matched.
  localparam logic [HW-1:0]   H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0]   H_ACT_END = HW'(H_ACTIVE);
  localparam logic [HW-1:0]   H_WIN_LO  = HW'(H_OFF);
  localparam logic [HW-1:0]   H_WIN_HI  = HW'(H_OFF + GAME_W * SCALE - 1);
  localparam logic [HW-1:0]   H_SYN_LO  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0]   H_SYN_HI  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0]   V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0]   V_ACT_END = VW'(V_ACTIVE);
  localparam logic [VW-1:0]   V_WIN_LO  = VW'(V_OFF);
  localparam logic [VW-1:0]   V_WIN_HI  = VW'(V_OFF + GAME_H * SCALE - 1);
  localparam logic [VW-1:0]   V_SYN_LO  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0]   V_SYN_HI  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [SUBW-1:0] SUB_LAST  = SUBW'(SCALE - 1);

  if (H_SLACK < 0) begin : g_bad_h_fit
    $error("pacman_vga_timing: scaled game width does not fit in H_ACTIVE");
  end
  if (V_SLACK < 0) begin : g_bad_v_fit
    $error("pacman_vga_timing: scaled game height does not fit in V_ACTIVE");
  end

  // Raster position: h_q/v_q is the position the next edge will describe.
  logic [HW-1:0]   h_q, h_d;
  logic [VW-1:0]   v_q, v_d;
  // Game coordinate of the current position plus the sub-pixel phase.
  logic [SXW-1:0]  sx_cur_q, sx_cur_d;
  logic [SYW-1:0]  sy_cur_q, sy_cur_d;
  logic [SUBW-1:0] hsub_q, hsub_d;
  logic [SUBW-1:0] vsub_q, vsub_d;

  logic            hsync_q, hsync_d;
  logic            vsync_q, vsync_d;
  logic            de_q, de_d;
  logic            game_q, game_d;
  logic            frame_q, frame_d;
  logic [SXW-1:0]  sx_q, sx_d;
  logic [SYW-1:0]  sy_q, sy_d;

  logic h_last, v_last;
  logic in_h_win, in_v_win, in_h_win_nxt, in_v_win_nxt;

  always_comb begin
    h_last = (h_q == H_LAST);
    v_last = (v_q == V_LAST);
    h_d    = h_last ? '0 : h_q + 1'b1;
    v_d    = v_q;
    if (h_last) begin
      v_d = v_last ? '0 : v_q + 1'b1;
    end
  end

  always_comb begin
    in_h_win     = (h_q >= H_WIN_LO) && (h_q <= H_WIN_HI);
    in_v_win     = (v_q >= V_WIN_LO) && (v_q <= V_WIN_HI);
    in_h_win_nxt = (h_d >= H_WIN_LO) && (h_d <= H_WIN_HI);
    in_v_win_nxt = (v_d >= V_WIN_LO) && (v_d <= V_WIN_HI);
  end

  // Column tracking. Entering or leaving the window clears the column, so
  // sx starts at 0 on every window line and can never run past GAME_W-1.
  always_comb begin
    sx_cur_d = '0;
    hsub_d   = '0;
    if (in_h_win && in_h_win_nxt) begin
      if (hsub_q == SUB_LAST) begin
        sx_cur_d = sx_cur_q + 1'b1;
      end else begin
        sx_cur_d = sx_cur_q;
        hsub_d   = hsub_q + 1'b1;
      end
    end
  end

  // Row tracking only moves at the end of a line.
  always_comb begin
    sy_cur_d = sy_cur_q;
    vsub_d   = vsub_q;
    if (h_last) begin
      sy_cur_d = '0;
      vsub_d   = '0;
      if (in_v_win && in_v_win_nxt) begin
        if (vsub_q == SUB_LAST) begin
          sy_cur_d = sy_cur_q + 1'b1;
        end else begin
          sy_cur_d = sy_cur_q;
          vsub_d   = vsub_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    de_d    = (h_q < H_ACT_END) && (v_q < V_ACT_END);
    game_d  = in_h_win && in_v_win;
    frame_d = (h_q == '0) && (v_q == '0);
    hsync_d = ((h_q >= H_SYN_LO) && (h_q <= H_SYN_HI)) ? SYNC_POL : ~SYNC_POL;
    vsync_d = ((v_q >= V_SYN_LO) && (v_q <= V_SYN_HI)) ? SYNC_POL : ~SYNC_POL;
    sx_d    = game_d ? sx_cur_q : '0;
    sy_d    = game_d ? sy_cur_q : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q      <= '0;
      v_q      <= '0;
      sx_cur_q <= '0;
      sy_cur_q <= '0;
      hsub_q   <= '0;
      vsub_q   <= '0;
      hsync_q  <= ~SYNC_POL;
      vsync_q  <= ~SYNC_POL;
      de_q     <= 1'b0;
      game_q   <= 1'b0;
      frame_q  <= 1'b0;
      sx_q     <= '0;
      sy_q     <= '0;
    end else begin
      h_q      <= h_d;
      v_q      <= v_d;
      sx_cur_q <= sx_cur_d;
      sy_cur_q <= sy_cur_d;
      hsub_q   <= hsub_d;
      vsub_q   <= vsub_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      de_q     <= de_d;
      game_q   <= game_d;
      frame_q  <= frame_d;
      sx_q     <= sx_d;
      sy_q     <= sy_d;
    end
  end

  assign game_pix_stb = game_q;
  assign frame_stb    = frame_q;
  assign sx           = sx_q;
  assign sy           = sy_q;

`ifdef PACMAN_TIMING_PIPE_EN
  pacman_sync_delay #(
    .DEPTH   (2),
    .WIDTH   (3),
    .RST_VAL ({~SYNC_POL, ~SYNC_POL, 1'b0})
  ) u_sync_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .din   ({hsync_q, vsync_q, de_q}),
    .dout  ({hsync, vsync, display_enabled})
  );
`else
  assign hsync           = hsync_q;
  assign vsync           = vsync_q;
  assign display_enabled = de_q;
`endif

endmodule

// File: tb/tb_pacman_vga_timing.sv
// tb_pacman_vga_timing
//   Directed bench for pacman_vga_timing. Two instances share clock/reset:
//   u_full runs the real 800x600 timing (first 16 lines are examined),
//   u_small runs a shrunk raster (56x36 total, 12x10 game at scale 2,
//   negative sync polarity) so whole frames and a mid-frame reset fit in
//   a short run. Expected values come from raster arithmetic in the bench.
`timescale 1ns/1ps
module tb_pacman_vga_timing;

`ifdef PACMAN_TIMING_PIPE_EN
  localparam int PD = 2;
`else
  localparam int PD = 0;
`endif

  localparam int NK = 16000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       f_hsync, f_vsync, f_de, f_game, f_frame;
  logic [7:0] f_sx;
  logic [8:0] f_sy;
  logic       s_hsync, s_vsync, s_de, s_game, s_frame;
  logic [3:0] s_sx;
  logic [3:0] s_sy;

  int tests_run = 0;
  int n_fail    = 0;
  int k         = 0;

  always #12.5 clk = ~clk;

  pacman_vga_timing u_full (
    .clk             (clk),
    .rst_n           (rst_n),
    .hsync           (f_hsync),
    .vsync           (f_vsync),
    .display_enabled (f_de),
    .game_pix_stb    (f_game),
    .frame_stb       (f_frame),
    .sx              (f_sx),
    .sy              (f_sy)
  );

  pacman_vga_timing #(
    .H_ACTIVE (40), .H_FP (4), .H_SYNC (6), .H_BP (6),
    .V_ACTIVE (30), .V_FP (1), .V_SYNC (2), .V_BP (3),
    .SYNC_POL (1'b0), .SCALE (2), .GAME_W (12), .GAME_H (10)
  ) u_small (
    .clk             (clk),
    .rst_n           (rst_n),
    .hsync           (s_hsync),
    .vsync           (s_vsync),
    .display_enabled (s_de),
    .game_pix_stb    (s_game),
    .frame_stb       (s_frame),
    .sx              (s_sx),
    .sy              (s_sy)
  );

  task automatic check(input string tag, input int obs, input int exp);
    tests_run++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    k++;
  endtask

  initial begin
    int pf, hf, vf, psd, hd, vd, ps, hs, vs, p2, h2, v2;
    int e_game, e_sx, e_sy, e_hs, e_vs, e_de, e_fr;
    int mis_f_win, mis_f_sync, mis_s_win, mis_s_sync;
    int f_line0_hs, f_line0_de, f_frames, f_first_k, f_first_sx, f_first_sy;
    int s_frames, s_last_fr, s_cnt_de, s_cnt_game, s_cnt_hs, s_cnt_vs;
    int s_max_sx, s_max_sy, n_e;

    mis_f_win = 0; mis_f_sync = 0; mis_s_win = 0; mis_s_sync = 0;
    f_line0_hs = 0; f_line0_de = 0; f_frames = 0;
    f_first_k = 0; f_first_sx = -1; f_first_sy = -1;
    s_frames = 0; s_last_fr = 0; s_cnt_de = 0; s_cnt_game = 0;
    s_cnt_hs = 0; s_cnt_vs = 0; s_max_sx = 0; s_max_sy = 0;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst full hsync", int'(f_hsync), 0);
    check("rst full vsync", int'(f_vsync), 0);
    check("rst full de", int'(f_de), 0);
    check("rst full game", int'(f_game), 0);
    check("rst full frame", int'(f_frame), 0);
    check("rst full sx", int'(f_sx), 0);
    check("rst full sy", int'(f_sy), 0);
    check("rst small hsync", int'(s_hsync), 1);
    check("rst small vsync", int'(s_vsync), 1);
    check("rst small de", int'(s_de), 0);

    @(negedge clk);
    rst_n = 1'b1;
    k = 0;

    for (int kk = 1; kk <= NK; kk++) begin
      tick();

      // Full-size raster
      pf = k - 1; hf = pf % 1056; vf = pf / 1056;
      e_game = (hf >= 176 && hf <= 623 && vf >= 12 && vf <= 587) ? 1 : 0;
      e_sx = (e_game == 1) ? (hf - 176) / 2 : 0;
      e_sy = (e_game == 1) ? (vf - 12) / 2 : 0;
      if (int'(f_game) != e_game || int'(f_sx) != e_sx || int'(f_sy) != e_sy) mis_f_win++;
      psd = k - 1 - PD;
      hd = (psd >= 0) ? psd % 1056 : -1;
      vd = (psd >= 0) ? psd / 1056 : -1;
      e_hs = (hd >= 840 && hd <= 967) ? 1 : 0;
      e_vs = (vd >= 601 && vd <= 604) ? 1 : 0;
      e_de = (hd >= 0 && hd < 800 && vd < 600) ? 1 : 0;
      e_fr = (pf == 0) ? 1 : 0;
      if (int'(f_hsync) != e_hs || int'(f_vsync) != e_vs || int'(f_de) != e_de ||
          int'(f_frame) != e_fr) mis_f_sync++;
      if (k <= 1056 + PD) begin
        f_line0_hs += int'(f_hsync);
        f_line0_de += int'(f_de);
      end
      if (f_frame) f_frames++;
      if (f_game && f_first_k == 0) begin
        f_first_k = k; f_first_sx = int'(f_sx); f_first_sy = int'(f_sy);
      end

      // Shrunk raster: 56x36, window h 8..31 v 5..24, sync h 44..49 v 31..32
      ps = (k - 1) % 2016; hs = ps % 56; vs = ps / 56;
      e_game = (hs >= 8 && hs <= 31 && vs >= 5 && vs <= 24) ? 1 : 0;
      e_sx = (e_game == 1) ? (hs - 8) / 2 : 0;
      e_sy = (e_game == 1) ? (vs - 5) / 2 : 0;
      if (int'(s_game) != e_game || int'(s_sx) != e_sx || int'(s_sy) != e_sy) mis_s_win++;
      p2 = (psd >= 0) ? psd % 2016 : -1;
      h2 = (p2 >= 0) ? p2 % 56 : -1;
      v2 = (p2 >= 0) ? p2 / 56 : -1;
      e_hs = (h2 >= 44 && h2 <= 49) ? 0 : 1;
      e_vs = (v2 >= 31 && v2 <= 32) ? 0 : 1;
      e_de = (h2 >= 0 && h2 < 40 && v2 < 30) ? 1 : 0;
      e_fr = (ps == 0) ? 1 : 0;
      if (int'(s_hsync) != e_hs || int'(s_vsync) != e_vs || int'(s_de) != e_de ||
          int'(s_frame) != e_fr) mis_s_sync++;
      if (k >= 1 + PD && k <= 6048 + PD) begin
        s_cnt_de += int'(s_de);
        s_cnt_hs += (s_hsync == 1'b0) ? 1 : 0;
        s_cnt_vs += (s_vsync == 1'b0) ? 1 : 0;
      end
      if (k <= 6048) begin
        s_cnt_game += int'(s_game);
        if (int'(s_sx) > s_max_sx) s_max_sx = int'(s_sx);
        if (int'(s_sy) > s_max_sy) s_max_sy = int'(s_sy);
      end
      if (s_frame) begin
        if (s_last_fr > 0) check("small frame period", k - s_last_fr, 2016);
        s_last_fr = k;
        s_frames++;
      end

      // Directed points
      if (k == 1) begin
        check("full frame_stb edge1", int'(f_frame), 1);
        check("full de edge1", int'(f_de), (PD == 0) ? 1 : 0);
        check("small frame_stb edge1", int'(s_frame), 1);
      end
      if (k == 2) check("full frame_stb edge2", int'(f_frame), 0);
      if (k == 840 + PD) check("full hsync before start", int'(f_hsync), 0);
      if (k == 841 + PD) check("full hsync start", int'(f_hsync), 1);
      if (k == 968 + PD) check("full hsync last", int'(f_hsync), 1);
      if (k == 969 + PD) check("full hsync after end", int'(f_hsync), 0);
      if (k == 12850) check("full sx h177", int'(f_sx), 0);
      if (k == 12851) check("full sx h178", int'(f_sx), 1);
      if (k == 13295) check("full sx h622", int'(f_sx), 223);
      if (k == 13296) check("full sx h623", int'(f_sx), 223);
      if (k == 13296) check("full game h623", int'(f_game), 1);
      if (k == 13297) check("full game h624", int'(f_game), 0);
      if (k == 13297) check("full sx h624", int'(f_sx), 0);
      if (k == 14352) check("full sy v13", int'(f_sy), 0);
      if (k == 14961) check("full sy v14", int'(f_sy), 1);
      if (k == 1297) check("small sy v23", int'(s_sy), 9);
      if (k == 1376) check("small sx v24 h31", int'(s_sx), 11);
      if (k == 1376) check("small sy v24 h31", int'(s_sy), 9);
      if (k == 1409) check("small game v25", int'(s_game), 0);
    end

    check("full window model", mis_f_win, 0);
    check("full sync model", mis_f_sync, 0);
    check("small window model", mis_s_win, 0);
    check("small sync model", mis_s_sync, 0);
    check("full line0 hsync width", f_line0_hs, 128);
    check("full line0 de width", f_line0_de, 800);
    check("full frame count", f_frames, 1);
    check("full first game edge", f_first_k, 12849);
    check("full first game sx", f_first_sx, 0);
    check("full first game sy", f_first_sy, 0);
    check("small frame count", s_frames, 8);
    check("small de per 3 frames", s_cnt_de, 3600);
    check("small game per 3 frames", s_cnt_game, 1440);
    check("small hsync per 3 frames", s_cnt_hs, 648);
    check("small vsync per 3 frames", s_cnt_vs, 336);
    check("small max sx", s_max_sx, 11);
    check("small max sy", s_max_sy, 9);

    // Mid-frame reset with the small raster at (20,15)
    while (k < 16989) tick();
    check("pre-reset small game", int'(s_game), 1);
    check("pre-reset small sx", int'(s_sx), 6);
    check("pre-reset small sy", int'(s_sy), 5);
    check("pre-reset full de", int'(f_de), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async small game", int'(s_game), 0);
    check("async small sx", int'(s_sx), 0);
    check("async small sy", int'(s_sy), 0);
    check("async small de", int'(s_de), 0);
    check("async small hsync", int'(s_hsync), 1);
    check("async full de", int'(f_de), 0);
    check("async full hsync", int'(f_hsync), 0);
    repeat (7) @(posedge clk);
    #1;
    check("held small frame", int'(s_frame), 0);
    check("held small de", int'(s_de), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("restart small frame", int'(s_frame), 1);
    check("restart full frame", int'(f_frame), 1);
    check("restart small game", int'(s_game), 0);
    check("restart full de", int'(f_de), (PD == 0) ? 1 : 0);
    n_e = 1;
    while (!s_de && n_e < 10) begin
      @(posedge clk);
      #1;
      n_e++;
    end
    check("restart small de edge", (s_de == 1'b1) ? n_e : -1, 1 + PD);

    $display("[TB] %0d tests run, %0d failed", tests_run, n_fail);
    $finish;
  end

endmodule

// File: doc/pacman_vga_timing.md
# pacman_vga_timing

Display-side source of the pixel interface consumed by the Pacman game renderer. Generates 800x600@60 VGA timing from one 40 MHz pixel clock and centres the 224x288 game field at integer scale 2 (448x576). Drives game coordinates `sx`/`sy`, `game_pix_stb`, `frame_stb` and `display_enabled`, plus `hsync`/`vsync` to the VGA connector.

## Interface
- `H_ACTIVE`, 800: visible columns
- `H_FP`/`H_SYNC`/`H_BP`, 40/128/88: horizontal porches/sync; H total 1056
- `V_ACTIVE`, 600: visible lines
- `V_FP`/`V_SYNC`/`V_BP`, 1/4/23: vertical; V total 628
- `SYNC_POL`, 1: active level of `hsync`/`vsync`
- `SCALE`, 2: physical pixels per game pixel, both axes
- `GAME_W`/`GAME_H`, `params::pacman::H_VISIBLE_AREA`/`V_VISIBLE_AREA` (224/288)

- `clk` in 1: 40 MHz pixel clock, the only clock
- `rst_n` in 1: reset, asynchronous, active-low
- `hsync` out 1: horizontal sync
- `vsync` out 1: vertical sync
- `display_enabled` out 1: inside 800x600 visible area
- `game_pix_stb` out 1: inside 448x576 game window
- `frame_stb` out 1: one-cycle pulse at position (0,0)
- `sx` out $clog2(GAME_W)=8: game column 0..223
- `sy` out $clog2(GAME_H)=9: game row 0..287

## Operation
- Position counters `h` (0..1055) and `v` (0..627); `h` wraps to 0 after 1055 and `v` increments; `v` wraps to 0 after 627.
- Window offsets: `H_OFF = (H_ACTIVE - GAME_W*SCALE)/2` = 176, `V_OFF = (V_ACTIVE - GAME_H*SCALE)/2` = 12. Compile-time check (`$error`) if either is negative.
- `display_enabled` = `h < H_ACTIVE && v < V_ACTIVE`.
- `game_pix_stb` = `h` in [176, 623] and `v` in [12, 587].
- `hsync` = `SYNC_POL` for `h` in [840, 967], else inverse. `vsync` = `SYNC_POL` for `v` in [601, 604], else inverse.
- `sx`/`sy` come from sub-counters `hsub`/`vsub` (0..SCALE-1). No divider.
  - `sx` increments when `hsub == SCALE-1` inside the window. It is 0 outside the window.
  - `sy` increments at line end (`h == 1055`) when `v` is inside the window and `vsub == SCALE-1`. It is 0 outside the window.
  - `sx` runs 0..223 exactly once per window line. `sy` runs 0..287 once per frame. Neither ever reaches 224/288.
- `frame_stb` = `h == 0 && v == 0`, exactly one cycle per 663168 clocks.

## Timing
- All outputs are registered; no combinational path from counters to ports.
- Reset (`rst_n` low, async): `h = v = hsub = vsub = 0`.
  - Outputs: `hsync = vsync = !SYNC_POL`; `display_enabled = game_pix_stb = frame_stb = 0`; `sx = sy = 0`.
- First rising edge after release: outputs describe position (0,0), so `frame_stb = 1` and `display_enabled = 1`. In general, outputs on edge n describe position n (raster order).
- Reset asserted mid-frame: outputs go to reset values immediately. After release the raster restarts at (0,0). No partial-frame recovery.

## Configuration
- `PACMAN_TIMING_PIPE_EN` defined: `hsync`, `vsync` and `display_enabled` are delayed by 2 extra cycles.
  - This aligns them with the renderer's two registered stages (sprite hit, then RGB).
  - `sx`, `sy`, `game_pix_stb` and `frame_stb` are not delayed.
  - Delay registers reset to the inactive values above.
- Not defined: all outputs share the same single-register timing.

## Structure
- Add package `params::vga800x600`: H/V active, porch and sync constants, `SYNC_POL`, and `H_TOTAL`/`V_TOTAL`.
- Game dimensions stay in `params::pacman`.
- One sub-module, `pacman_sync_delay`: parameterised depth/width shift register with async active-low reset and reset value. It is instantiated only under `PACMAN_TIMING_PIPE_EN`.

## Test plan
- Release reset, run 2 frames:
  - `frame_stb` at edge 1 and edge 663169.
  - Period between pulses 663168.
  - `display_enabled` high for 480000 cycles per frame.
- Line check:
  - `hsync` pulse is 128 cycles, starting 840 cycles after line start.
  - `vsync` is 4 lines (4224 cycles), starting at line 601.
- Window scan:
  - First `game_pix_stb` at (176,12) with `sx = 0`, `sy = 0`.
  - `sx = 1` at h = 178; `sx = 223` at h = 622..623.
  - `sy = 1` at v = 14; `sy = 287` at v = 586..587.
  - `game_pix_stb` high for 258048 cycles per frame.
- Assert `rst_n` low at (500,300) for 7 cycles:
  - Outputs go to reset values asynchronously.
  - After release, next edge gives (0,0) with `frame_stb = 1`.
- With `PACMAN_TIMING_PIPE_EN`:
  - `display_enabled` rises 2 cycles after `frame_stb`.
  - `hsync` is asserted 2 cycles later than in the default build.
  - `sx`/`sy` are unchanged.
- Check `sx` never exceeds 223 and `sy` never exceeds 287 over 3 full frames.
